inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL be parameterised as follows.
- DEPTH, default 8: number of instruction entries; power of two, minimum 4.
REQ-002 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports are listed below as name / direction / width / meaning.
- clk / in / 1 / clock; all state updates on rising edge.
- rst / in / 1 / synchronous active-high reset.
- flush_iq_i / in / 1 / flush from writeback; discard all entries.
- fetch_valid_i / in / 1 / fetch packet present; slot 0 always valid when asserted.
- fetch_pc_i / in / 64 / PC of slot-0 instruction.
- fetch_inst0_i / in / 32 / slot-0 instruction.
- fetch_inst1_valid_i / in / 1 / slot-1 instruction present; its PC is fetch_pc_i+4.
- fetch_inst1_i / in / 32 / slot-1 instruction.
- iq_ready_o / out / 1 / queue can accept a full two-instruction packet.
- stall_decoder_inst0_i / in / 1 / decoder not accepting this cycle.
- inst0_f1_valid_o, inst1_f1_valid_o / out / 1 each / head and head+1 entry valid.
- inst0_f1_pc_o, inst1_f1_pc_o / out / 64 each / PC of head and head+1 entry.
- inst0_f1_inst_o, inst1_f1_inst_o / out / 32 each / instruction of head and head+1 entry.
- iq_count_o / out / clog2(DEPTH)+1 / current occupancy.

Function
REQ-003 Storage SHALL be a circular buffer with read and write pointers of clog2(DEPTH)+1 bits; the MSB distinguishes full from empty and wraps modulo 2*DEPTH.
REQ-004 iq_ready_o SHALL be combinational and equal (count <= DEPTH-2); freeing by a same-cycle pop is not counted.
REQ-005 Push SHALL occur only when fetch_valid_i & iq_ready_o & !flush_iq_i; otherwise fetch holds its packet and nothing is written.
REQ-006 A push SHALL write {fetch_pc_i, fetch_inst0_i} at wr_ptr and, if fetch_inst1_valid_i, {fetch_pc_i+4, fetch_inst1_i} at wr_ptr+1; push amount is 1 or 2; PC arithmetic is 64-bit modulo 2^64.
REQ-007 Outputs SHALL be combinational from storage: inst0_f1_* reads rd_ptr, inst1_f1_* reads rd_ptr+1; inst0_f1_valid_o = (count>=1); inst1_f1_valid_o = (count>=2).
REQ-008 When both valids are low, data outputs SHALL be zero (pc 64'h0, inst 32'h0).
REQ-009 Pop amount SHALL be 0 if stall_decoder_inst0_i, else inst0_f1_valid_o + inst1_f1_valid_o (0, 1 or 2); rd_ptr advances by the pop amount.
REQ-010 Pushed entries SHALL first be visible at the outputs in the cycle after the push (one-cycle latency); there is no bypass from fetch to the outputs.
REQ-011 Push and pop in the same cycle SHALL both take effect: count_next = count + push_amt - pop_amt.
REQ-012 Flush SHALL have priority over push and pop: on the next edge both pointers and count become 0, and the same-cycle fetch packet is dropped.
REQ-013 Count SHALL never exceed DEPTH nor underflow; REQ-004 and REQ-009 guarantee this, and an assertion checks it.

Reset
REQ-014 When rst is sampled high, the block SHALL set rd_ptr=0, wr_ptr=0, count=0; hence iq_ready_o=1, all valid outputs 0, all data outputs 0, iq_count_o=0.
REQ-015 Storage contents SHALL need no reset; reset asserted mid-operation discards all entries exactly as a flush does and takes priority over flush.

Structure
REQ-016 A shared package SHALL hold XLEN=64, ILEN=32, IQ_DEPTH=8, and the typedef iq_entry_t {pc[63:0], inst[31:0]}.
REQ-017 No sub-module SHALL be used; the 2-write/2-read register array is inline.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- Reset, then push pc=0x1000 insts A,B: next cycle inst0=(0x1000,A), inst1=(0x1004,B), count=2.
- Single push pc=0x2000 with inst1_valid=0 and stall=1: inst0_valid=1, inst1_valid=0; release stall -> pop 1 -> count=0.
- Fill to 7 entries with DEPTH=8: iq_ready_o=0; a fetch held high is not written until count<=6.
- Continuous push 2 / pop 2 for 20 cycles across pointer wrap: PCs at the outputs are strictly sequential, no loss or duplication, count stays constant.
- Flush with count=5 and simultaneous push: next cycle count=0, valids 0, the pushed packet is absent.
- Stall held for 3 cycles with count=4: outputs stable and count unchanged; after release two entries pop per cycle.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types and sizes for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int XLEN     = 64;
  localparam int ILEN     = 32;
  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between fetch and decode.
// Accepts up to two instructions per cycle and presents the two oldest.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_iq_i,
  input  logic                       fetch_valid_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [ILEN-1:0]            fetch_inst0_i,
  input  logic                       fetch_inst1_valid_i,
  input  logic [ILEN-1:0]            fetch_inst1_i,
  output logic                       iq_ready_o,
  input  logic                       stall_decoder_inst0_i,
  output logic                       inst0_f1_valid_o,
  output logic                       inst1_f1_valid_o,
  output logic [XLEN-1:0]            inst0_f1_pc_o,
  output logic [XLEN-1:0]            inst1_f1_pc_o,
  output logic [ILEN-1:0]            inst0_f1_inst_o,
  output logic [ILEN-1:0]            inst1_f1_inst_o,
  output logic [$clog2(DEPTH):0]     iq_count_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  iq_entry_t mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr1;
  logic [PW-1:0] wr_ptr1;
  logic [PW-1:0] count;
  logic [PW-1:0] push_amt;
  logic [PW-1:0] pop_amt;
  logic [PW:0]   count_next;
  logic          push;
  iq_entry_t     head0;
  iq_entry_t     head1;

  // Pointer MSB disambiguates full/empty, so the difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_ptr1 = wr_ptr + PW'(1);

  assign iq_ready_o = (count <= PW'(DEPTH - 2));
  assign push       = fetch_valid_i & iq_ready_o & ~flush_iq_i;

  always_comb begin
    push_amt = '0;
    if (push)
      push_amt = fetch_inst1_valid_i ? PW'(2) : PW'(1);
  end

  assign inst0_f1_valid_o = (count != '0);
  assign inst1_f1_valid_o = (count >= PW'(2));

  always_comb begin
    pop_amt = '0;
    if (!stall_decoder_inst0_i)
      pop_amt = PW'(inst0_f1_valid_o) + PW'(inst1_f1_valid_o);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: fetch_pc_i, inst: fetch_inst0_i};
      if (fetch_inst1_valid_i)
        mem[wr_ptr1[AW-1:0]] <= '{pc: fetch_pc_i + 64'd4,
                                  inst: fetch_inst1_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_iq_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr + pop_amt;
      wr_ptr <= wr_ptr + push_amt;
    end
  end

  assign head0 = mem[rd_ptr[AW-1:0]];
  assign head1 = mem[rd_ptr1[AW-1:0]];

  assign inst0_f1_pc_o   = inst0_f1_valid_o ? head0.pc   : '0;
  assign inst0_f1_inst_o = inst0_f1_valid_o ? head0.inst : '0;
  assign inst1_f1_pc_o   = inst1_f1_valid_o ? head1.pc   : '0;
  assign inst1_f1_inst_o = inst1_f1_valid_o ? head1.inst : '0;

  assign iq_count_o = count;

  // Underflow wraps to a huge value, so one bound catches both directions.
  assign count_next = {1'b0, count} + {1'b0, push_amt} - {1'b0, pop_amt};

  always_ff @(posedge clk) begin
    if (!rst && !flush_iq_i)
      assert (count_next <= (PW+1)'(DEPTH));
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue model predicts occupancy,
// handshake and the two head entries every cycle.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int D  = IQ_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_iq_i;
  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic [ILEN-1:0] fetch_inst0_i;
  logic            fetch_inst1_valid_i;
  logic [ILEN-1:0] fetch_inst1_i;
  logic            iq_ready_o;
  logic            stall_decoder_inst0_i;
  logic            inst0_f1_valid_o;
  logic            inst1_f1_valid_o;
  logic [XLEN-1:0] inst0_f1_pc_o;
  logic [XLEN-1:0] inst1_f1_pc_o;
  logic [ILEN-1:0] inst0_f1_inst_o;
  logic [ILEN-1:0] inst1_f1_inst_o;
  logic [CW-1:0]   iq_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  iq_entry_t sb [$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(D)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_iq_i            (flush_iq_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_pc_i            (fetch_pc_i),
    .fetch_inst0_i         (fetch_inst0_i),
    .fetch_inst1_valid_i   (fetch_inst1_valid_i),
    .fetch_inst1_i         (fetch_inst1_i),
    .iq_ready_o            (iq_ready_o),
    .stall_decoder_inst0_i (stall_decoder_inst0_i),
    .inst0_f1_valid_o      (inst0_f1_valid_o),
    .inst1_f1_valid_o      (inst1_f1_valid_o),
    .inst0_f1_pc_o         (inst0_f1_pc_o),
    .inst1_f1_pc_o         (inst1_f1_pc_o),
    .inst0_f1_inst_o       (inst0_f1_inst_o),
    .inst1_f1_inst_o       (inst1_f1_inst_o),
    .iq_count_o            (iq_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [63:0] pc,
                       input logic [31:0] i0, input logic i1v,
                       input logic [31:0] i1, input logic stall,
                       input logic flush);
    fetch_valid_i         = fv;
    fetch_pc_i            = pc;
    fetch_inst0_i         = i0;
    fetch_inst1_valid_i   = i1v;
    fetch_inst1_i         = i1;
    stall_decoder_inst0_i = stall;
    flush_iq_i            = flush;
  endtask

  // Called at a negedge: compare DUT against the model, then advance the
  // model with the inputs that the coming posedge will see.
  task automatic tick();
    int sz;
    int np;
    sz = sb.size();
    chk("count", 64'(iq_count_o), 64'(sz));
    chk("ready", 64'(iq_ready_o), 64'(sz <= D - 2));
    chk("v0", 64'(inst0_f1_valid_o), 64'(sz >= 1));
    chk("v1", 64'(inst1_f1_valid_o), 64'(sz >= 2));
    if (sz >= 1) begin
      chk("pc0", inst0_f1_pc_o, sb[0].pc);
      chk("inst0", 64'(inst0_f1_inst_o), 64'(sb[0].inst));
    end else begin
      chk("pc0_zero", inst0_f1_pc_o, 64'h0);
      chk("inst0_zero", 64'(inst0_f1_inst_o), 64'h0);
      chk("pc1_zero", inst1_f1_pc_o, 64'h0);
      chk("inst1_zero", 64'(inst1_f1_inst_o), 64'h0);
    end
    if (sz >= 2) begin
      chk("pc1", inst1_f1_pc_o, sb[1].pc);
      chk("inst1", 64'(inst1_f1_inst_o), 64'(sb[1].inst));
    end
    if (rst || flush_iq_i) begin
      sb.delete();
    end else begin
      np = stall_decoder_inst0_i ? 0 : (sz >= 2 ? 2 : sz);
      for (int k = 0; k < np; k++) void'(sb.pop_front());
      if (fetch_valid_i && sz <= D - 2) begin
        sb.push_back('{pc: fetch_pc_i, inst: fetch_inst0_i});
        if (fetch_inst1_valid_i)
          sb.push_back('{pc: fetch_pc_i + 64'd4, inst: fetch_inst1_i});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pc;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 64'(iq_count_o), 64'h0);
    chk("rst_ready", 64'(iq_ready_o), 64'h1);
    chk("rst_v0", 64'(inst0_f1_valid_o), 64'h0);
    chk("rst_pc0", inst0_f1_pc_o, 64'h0);

    // Pair push, visible one cycle later
    drive(1, 64'h1000, 32'hAAAA_0001, 1, 32'hBBBB_0002, 0, 0);
    tick();
    chk("pair_count", 64'(iq_count_o), 64'h2);
    chk("pair_pc1", inst1_f1_pc_o, 64'h1004);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Single push under stall, then release
    drive(1, 64'h2000, 32'h1111_2222, 0, 32'hDEAD_BEEF, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("single_v1", 64'(inst1_f1_valid_o), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("single_drained", 64'(iq_count_o), 64'h0);

    // Fill to 7 while stalled; held fetch must wait for room
    pc = 64'h3000;
    for (int k = 0; k < 4; k++) begin
      drive(1, pc, 32'h3000_0000 + k, (k != 3), 32'h3100_0000 + k, 1, 0);
      tick();
      pc += 8;
    end
    chk("full_count", 64'(iq_count_o), 64'h7);
    chk("full_ready", 64'(iq_ready_o), 64'h0);
    drive(1, 64'h4000, 32'h4444_0000, 1, 32'h4444_0001, 1, 0);
    tick();
    tick();
    chk("held_count", 64'(iq_count_o), 64'h7);
    stall_decoder_inst0_i = 1'b0;
    tick();
    fetch_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("fill_drained", 64'(iq_count_o), 64'h0);

    // Streaming push2/pop2 across pointer wrap
    pc = 64'h5000;
    for (int k = 0; k < 21; k++) begin
      drive(1, pc, 32'h5000_0000 + k, 1, 32'h5100_0000 + k, 0, 0);
      tick();
      pc += 8;
    end
    chk("stream_count", 64'(iq_count_o), 64'h2);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // PC+4 wraps modulo 2^64
    drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0000, 1, 32'h7777_0001, 1, 0);
    tick();
    chk("wrap_pc1", inst1_f1_pc_o, 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Flush at count 5 with a simultaneous push
    pc = 64'h6000;
    for (int k = 0; k < 3; k++) begin
      drive(1, pc, 32'h6000_0000 + k, (k != 2), 32'h6100_0000 + k, 1, 0);
      tick();
      pc += 8;
    end
    chk("pre_flush_count", 64'(iq_count_o), 64'h5);
    drive(1, 64'h6800, 32'h6800_0000, 1, 32'h6800_0001, 1, 1);
    tick();
    chk("flush_count", 64'(iq_count_o), 64'h0);
    chk("flush_v0", 64'(inst0_f1_valid_o), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Stall for 3 cycles at count 4, then pop two per cycle
    drive(1, 64'h8000, 32'h8000_0000, 1, 32'h8000_0001, 1, 0);
    tick();
    drive(1, 64'h8008, 32'h8000_0002, 1, 32'h8000_0003, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    tick();
    chk("stall_count", 64'(iq_count_o), 64'h4);
    chk("stall_pc0", inst0_f1_pc_o, 64'h8000);
    stall_decoder_inst0_i = 1'b0;
    tick();
    chk("release_count", 64'(iq_count_o), 64'h2);
    tick();
    tick();

    // Mid-operation reset discards contents
    drive(1, 64'h9000, 32'h9000_0000, 1, 32'h9000_0001, 1, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
